// File: rtl/imgproc_pkg.sv
// Shared types and frame constants for the image-processor control path.
package imgproc_pkg;
    localparam int unsigned FRAME_W      = 320;
    localparam int unsigned FRAME_H      = 320;
    localparam int unsigned FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int unsigned MAX_ANGLE    = 90;
    localparam int unsigned PIX_CNT_W    = 17;
    localparam int unsigned WD_CNT_W     = 18;

    typedef enum logic [1:0] {
        OP_ROTATE     = 2'd0,
        OP_ZOOM       = 2'd1,
        OP_BLACKWHITE = 2'd2,
        OP_INVERSION  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_COPY = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;
endpackage

// File: rtl/imgproc_seq_ctrl_if.sv
// Host command handshake, datapath control and status bundle of the sequencer.
interface imgproc_seq_ctrl_if;
    logic [3:0] cmd;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ack;
    logic       busy;
    logic       refresh;
    logic       error;
    logic [1:0] func_sel;
    logic [6:0] angle;
    logic [3:0] zoom;
    logic       proc_start;
    logic       copy_start;
    logic       wr_tmp_stb;
    logic       wr_orig_stb;
    logic       abort;

    // master: host plus datapath write strobes; slave: the sequencer
    modport master (
        output cmd, cmd_data, cmd_valid, wr_tmp_stb, wr_orig_stb,
        input  cmd_ack, busy, refresh, error, func_sel, angle, zoom,
               proc_start, copy_start, abort
    );

    modport slave (
        input  cmd, cmd_data, cmd_valid, wr_tmp_stb, wr_orig_stb,
        output cmd_ack, busy, refresh, error, func_sel, angle, zoom,
               proc_start, copy_start, abort
    );
endinterface

// File: rtl/imgproc_cmd_check.sv
// Combinational opcode/argument legality check and config-field decode.
module imgproc_cmd_check #(
    parameter int unsigned MAX_ANGLE = 90
) (
    input  logic [3:0] i_cmd,
    input  logic [7:0] i_cmd_data,
    output logic       o_legal,
    output logic [1:0] o_func_sel,
    output logic       o_load_angle,
    output logic       o_load_zoom,
    output logic [6:0] o_angle,
    output logic [3:0] o_zoom
);
    import imgproc_pkg::*;

    localparam logic [7:0] ANGLE_LIM = 8'(MAX_ANGLE);

    always_comb begin
        o_func_sel   = i_cmd[1:0];
        o_angle      = i_cmd_data[6:0];
        o_zoom       = i_cmd_data[3:0];
        o_legal      = 1'b0;
        o_load_angle = 1'b0;
        o_load_zoom  = 1'b0;
        if (i_cmd[3:2] == 2'b00) begin
            case (op_e'(i_cmd[1:0]))
                OP_ROTATE: begin
                    o_legal      = (i_cmd_data <= ANGLE_LIM);
                    o_load_angle = o_legal;
                end
                OP_ZOOM: begin
                    o_legal     = (i_cmd_data != 8'd0) && (i_cmd_data <= 8'd15);
                    o_load_zoom = o_legal;
                end
                default: o_legal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/imgproc_seq_ctrl.sv
// Two-pass frame sequencer: validates a host command, runs process and copy
// passes against per-pass pixel counts, and guards each pass with a watchdog.
module imgproc_seq_ctrl #(
    parameter int unsigned PIXELS    = imgproc_pkg::FRAME_PIXELS,
    parameter int unsigned TIMEOUT   = 262143,
    parameter int unsigned MAX_ANGLE = imgproc_pkg::MAX_ANGLE
) (
    input  logic               clk,
    input  logic               rst_n,
    imgproc_seq_ctrl_if.slave  bus
);
    import imgproc_pkg::*;

    localparam logic [PIX_CNT_W-1:0] PIX_TERM = PIX_CNT_W'(PIXELS);
    localparam logic [WD_CNT_W-1:0]  WD_TERM  = WD_CNT_W'(TIMEOUT);

    seq_state_e r_state, w_state_next;

    logic [PIX_CNT_W-1:0] r_pix_cnt, w_pix_next, w_pix_inc;
    logic [WD_CNT_W-1:0]  r_wd_cnt,  w_wd_next,  w_wd_inc;

    logic       r_cmd_ack,    w_cmd_ack_next;
    logic       r_busy,       w_busy_next;
    logic       r_refresh,    w_refresh_next;
    logic       r_error,      w_error_next;
    logic       r_proc_start, w_proc_start_next;
    logic       r_copy_start, w_copy_start_next;
    logic       r_abort,      w_abort_next;
    logic [1:0] r_func_sel,   w_func_sel_next;
    logic [6:0] r_angle,      w_angle_next;
    logic [3:0] r_zoom,       w_zoom_next;

    logic       w_legal, w_load_angle, w_load_zoom;
    logic [1:0] w_func_sel;
    logic [6:0] w_angle;
    logic [3:0] w_zoom;
    logic       w_cmd_take, w_active, w_stb, w_pix_done, w_wd_expire;

    imgproc_cmd_check #(.MAX_ANGLE(MAX_ANGLE)) u_cmd_check (
        .i_cmd        (bus.cmd),
        .i_cmd_data   (bus.cmd_data),
        .o_legal      (w_legal),
        .o_func_sel   (w_func_sel),
        .o_load_angle (w_load_angle),
        .o_load_zoom  (w_load_zoom),
        .o_angle      (w_angle),
        .o_zoom       (w_zoom)
    );

    // The ack cycle itself is skipped so one held request yields one ack.
    assign w_cmd_take = (r_state == S_IDLE) && bus.cmd_valid && !r_cmd_ack;
    assign w_active   = (r_state == S_PROC) || (r_state == S_COPY);
    assign w_stb      = (r_state == S_PROC) ? bus.wr_tmp_stb :
                        (r_state == S_COPY) ? bus.wr_orig_stb : 1'b0;

    assign w_pix_inc   = (w_stb && (r_pix_cnt != '1)) ? r_pix_cnt + 1'b1 : r_pix_cnt;
    assign w_wd_inc    = (r_wd_cnt != '1) ? r_wd_cnt + 1'b1 : r_wd_cnt;
    assign w_pix_done  = w_active && (w_pix_inc >= PIX_TERM);
    assign w_wd_expire = w_active && !w_pix_done && (w_wd_inc >= WD_TERM);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Abort reuses DONE so busy drops exactly one cycle after the abort pulse.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_cmd_take && w_legal) w_state_next = S_PROC;
            S_PROC: if (w_pix_done) w_state_next = S_COPY;
                    else if (w_wd_expire) w_state_next = S_DONE;
            S_COPY: if (w_pix_done || w_wd_expire) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_ack_next    = 1'b0;
        w_proc_start_next = 1'b0;
        w_copy_start_next = 1'b0;
        w_refresh_next    = 1'b0;
        w_abort_next      = 1'b0;
        w_busy_next       = r_busy;
        w_error_next      = r_error;
        w_func_sel_next   = r_func_sel;
        w_angle_next      = r_angle;
        w_zoom_next       = r_zoom;
        w_pix_next        = '0;
        w_wd_next         = '0;
        unique case (r_state)
            S_IDLE: begin
                w_busy_next = 1'b0;
                if (w_cmd_take) begin
                    w_cmd_ack_next = 1'b1;
                    if (w_legal) begin
                        w_busy_next       = 1'b1;
                        w_proc_start_next = 1'b1;
                        w_error_next      = 1'b0;
                        w_func_sel_next   = w_func_sel;
                        if (w_load_angle) w_angle_next = w_angle;
                        if (w_load_zoom)  w_zoom_next  = w_zoom;
                    end else begin
                        w_error_next = 1'b1;
                    end
                end
            end
            S_PROC, S_COPY: begin
                if (w_pix_done) begin
                    w_copy_start_next = (r_state == S_PROC);
                    w_refresh_next    = (r_state == S_COPY);
                end else if (w_wd_expire) begin
                    w_abort_next = 1'b1;
                    w_error_next = 1'b1;
                end else begin
                    w_pix_next = w_pix_inc;
                    w_wd_next  = w_wd_inc;
                end
            end
            S_DONE: w_busy_next = 1'b0;
            default: w_busy_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix_cnt    <= '0;
            r_wd_cnt     <= '0;
            r_cmd_ack    <= 1'b0;
            r_busy       <= 1'b0;
            r_refresh    <= 1'b0;
            r_error      <= 1'b0;
            r_proc_start <= 1'b0;
            r_copy_start <= 1'b0;
            r_abort      <= 1'b0;
            r_func_sel   <= '0;
            r_angle      <= '0;
            r_zoom       <= '0;
        end else begin
            r_pix_cnt    <= w_pix_next;
            r_wd_cnt     <= w_wd_next;
            r_cmd_ack    <= w_cmd_ack_next;
            r_busy       <= w_busy_next;
            r_refresh    <= w_refresh_next;
            r_error      <= w_error_next;
            r_proc_start <= w_proc_start_next;
            r_copy_start <= w_copy_start_next;
            r_abort      <= w_abort_next;
            r_func_sel   <= w_func_sel_next;
            r_angle      <= w_angle_next;
            r_zoom       <= w_zoom_next;
        end
    end

    assign bus.cmd_ack    = r_cmd_ack;
    assign bus.busy       = r_busy;
    assign bus.refresh    = r_refresh;
    assign bus.error      = r_error;
    assign bus.proc_start = r_proc_start;
    assign bus.copy_start = r_copy_start;
    assign bus.abort      = r_abort;
    assign bus.func_sel   = r_func_sel;
    assign bus.angle      = r_angle;
    assign bus.zoom       = r_zoom;
endmodule

// File: doc/imgproc_seq_ctrl.md
# imgproc_seq_ctrl

Command sequencer for the image processor. It accepts one host command at a time over the `cmd`/`cmd_valid`/`cmd_ack` handshake and validates its opcode and argument. It then configures the function-select and argument registers of the pixel datapath and runs the two-pass frame operation: a process pass (original buffer → function → temp buffer) followed by a copy pass (temp buffer → original buffer). It also owns the `busy`, `refresh` and `error` status outputs, including a per-pass watchdog.

## Interface
Parameters:
- `PIXELS`, default 102400: pixel writes per pass (320×320 frame).
- `TIMEOUT`, default 262143: maximum cycles allowed per pass before abort.
- `MAX_ANGLE`, default 90: largest legal rotate argument.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd`  in  4  opcode: 0 ROTATE, 1 ZOOM, 2 BLACKWHITE, 3 INVERSION; 4–15 illegal.
- `cmd_data`  in  8  argument: angle for ROTATE, zoom factor for ZOOM, ignored otherwise.
- `cmd_valid`  in  1  host holds high until `cmd_ack`.
- `cmd_ack`  out  1  one-cycle acceptance/rejection pulse.
- `busy`  out  1  high from acceptance until the cycle after `refresh` or abort.
- `refresh`  out  1  one-cycle pulse: frame rewritten.
- `error`  out  1  sticky: illegal command or watchdog abort.
- `func_sel`  out  2  datapath mux select; stable while `busy`.
- `angle`  out  7  rotate angle 0..90; stable while `busy`.
- `zoom`  out  4  zoom divisor 1..15; stable while `busy`.
- `proc_start`  out  1  one-cycle pulse that launches the original-buffer reader.
- `copy_start`  out  1  one-cycle pulse that launches the temp-buffer reader.
- `wr_tmp_stb`  in  1  one pulse per pixel written to the temp buffer.
- `wr_orig_stb`  in  1  one pulse per pixel written to the original buffer.
- `abort`  out  1  one-cycle pulse that returns the datapath readers to idle.

## Operation
- States: `IDLE`, `PROC`, `COPY`, `DONE`.
- Reset: state `IDLE`; every output 0, including `func_sel`, `angle`, `zoom` and `error`.

IDLE
- With `cmd_valid`=1, the command is validated in that cycle.
- Illegal if any of: `cmd` > 3; ROTATE with `cmd_data` > `MAX_ANGLE`; ZOOM with `cmd_data` = 0 or `cmd_data` > 15.
- Illegal command: `cmd_ack`=1 and `error`=1 next cycle; state stays `IDLE`; config registers unchanged.
- Legal command: `cmd_ack`=1, `busy`=1 and `proc_start`=1 next cycle.
  - `error` clears in the same cycle.
  - `func_sel` ← `cmd[1:0]`.
  - ROTATE loads `angle` ← `cmd_data[6:0]`.
  - ZOOM loads `zoom` ← `cmd_data[3:0]`.
  - Other opcodes leave `angle`/`zoom` unchanged.
  - Pixel counter and watchdog clear; state → `PROC`.

PROC
- Count `wr_tmp_stb`.
- When the count reaches `PIXELS`: `copy_start` pulses next cycle; counter and watchdog clear; state → `COPY`.

COPY
- Count `wr_orig_stb`.
- When the count reaches `PIXELS`: `refresh` pulses next cycle; state → `DONE`.

DONE
- One cycle; `busy`=0 next cycle; state → `IDLE`.

Command handling while busy
- `cmd_valid` is not acknowledged while `busy`=1. The command is accepted or rejected only after the return to `IDLE`.

Watchdog
- Free-running counter in `PROC` and `COPY`.
- Reaching `TIMEOUT` before the pixel count completes: `abort`=1 and `error`=1 next cycle; `busy`=0 the cycle after; state → `IDLE`; no `refresh`.

Counter and strobe rules
- Pixel counter is 17 bits; watchdog is 18 bits. Both saturate and never wrap.
- Strobes arriving in `IDLE` or `DONE` are ignored.
- A strobe in the same cycle as the terminal count is counted. The transition wins over a simultaneous watchdog expiry.

Reset mid-operation
- Synchronous return to `IDLE` with all outputs 0. No `abort` pulse is issued; the datapath shares `rst_n`.

## Timing
- Acceptance latency: `cmd_valid` sampled high at edge N → `cmd_ack`/`busy`/`proc_start` high after edge N+1 (registered, 1 cycle).
- `cmd_ack` is high for exactly 1 cycle per command. The host must drop `cmd_valid` in the cycle after `cmd_ack`, otherwise the command is re-accepted.
- Last `wr_tmp_stb` at edge M → `copy_start` at M+1.
- Last `wr_orig_stb` at edge K → `refresh` at K+1, `busy`=0 at K+2.
- Watchdog expiry at edge T → `abort`/`error` at T+1, `busy`=0 at T+2.
- `func_sel`, `angle` and `zoom` change only in the cycle `cmd_ack` rises.

## Structure
- Shared package `imgproc_pkg`:
  - Opcode enum `op_e` (ROTATE, ZOOM, BLACKWHITE, INVERSION).
  - State enum `seq_state_e`.
  - Constants `FRAME_W`=320, `FRAME_H`=320, `FRAME_PIXELS`=102400.
  - Constant `MAX_ANGLE`=90.
- Sub-module `imgproc_cmd_check`: combinational legality check and argument decode. It is the only instance; counters and the FSM stay in the top module.

## Test plan
- Reset, then ROTATE `cmd_data`=10: `cmd_ack` 1 cycle later, `angle`=10, `func_sel`=0, `proc_start` pulse. Drive 102400 `wr_tmp_stb` → `copy_start`. Drive 102400 `wr_orig_stb` → `refresh` 1 cycle later, `busy` low 2 cycles after the last strobe.
- `cmd`=5: `cmd_ack`=1, `error`=1, `busy` stays 0. Then a legal INVERSION: `error` clears, `func_sel`=3.
- ZOOM `cmd_data`=0 and ROTATE `cmd_data`=91: both rejected with `error`=1. ZOOM `cmd_data`=2: accepted, `zoom`=2.
- `cmd_valid` held during a busy BLACKWHITE run: no `cmd_ack` until the cycle after the return to `IDLE`; then accepted.
- `TIMEOUT`=100 with only 50 strobes: `abort`=1 and `error`=1 at cycle 101 of `PROC`, no `refresh`, `busy`=0 the next cycle.
- `rst_n` low for 1 cycle mid-`COPY`: all outputs 0 on the next edge; a new command is accepted normally afterwards.
